// File: rtl/alu_branch_table_if.sv
// rtl/alu_branch_table_if.sv - execute-stage ALU and branch-table signal bundle
//
// Purpose: groups the ALU and branch-table signals of alu_branch_table.
// Ports (master drives, slave receives):
//   aluop[1:0], funct[5:0], a[31:0], b[31:0]        -> ALU control and operands
//   aluctl[3:0], alu_out[31:0], zero                <- decoded control and result
//   pc4[31:0]                                       -> lookup key
//   pc4d[31:0], wrt, wrp, bdest_in[31:0], pin       -> update key, strobes, data
//   hit, bdest[31:0], pred                          <- lookup result
interface alu_branch_table_if;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluctl;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] pc4;
  logic [31:0] pc4d;
  logic        wrt;
  logic        wrp;
  logic [31:0] bdest_in;
  logic        pin;
  logic        hit;
  logic [31:0] bdest;
  logic        pred;

  modport master (
    output aluop, funct, a, b, pc4, pc4d, wrt, wrp, bdest_in, pin,
    input  aluctl, alu_out, zero, hit, bdest, pred
  );

  modport slave (
    input  aluop, funct, a, b, pc4, pc4d, wrt, wrp, bdest_in, pin,
    output aluctl, alu_out, zero, hit, bdest, pred
  );
endinterface

// File: rtl/alu_branch_table.sv
// rtl/alu_branch_table.sv - MIPS execute-stage ALU plus 1-bit branch target table
//
// Purpose: combinational ALU with ALU-control decode, and a direct-mapped
// branch target/prediction table looked up by fetch PC+4 and updated from
// branch resolution.
// Ports:
//   clk    rising-edge clock (table only)
//   rst_n  async active-low reset, clears every table entry
//   bus    alu_branch_table_if.slave, see the interface for signal list
module alu_branch_table #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_branch_table_if.slave bus
);
  localparam int TAG_W = 32 - IDX_W - 2;

  // ALU control decode
  logic [3:0] ctl;

  always_comb begin
    ctl = 4'b0000;
    case (bus.aluop)
      2'b00: ctl = 4'b0010;
      2'b01: ctl = 4'b0110;
      2'b10: begin
        case (bus.funct)
          6'b100000: ctl = 4'b0010;
          6'b100010: ctl = 4'b0110;
          6'b100100: ctl = 4'b0000;
          6'b100101: ctl = 4'b0001;
          6'b100110: ctl = 4'b1101;
          6'b100111: ctl = 4'b1100;
          6'b101010: ctl = 4'b0111;
          default:   ctl = 4'b0000;
        endcase
      end
      default: ctl = 4'b0000;
    endcase
  end

  // ALU datapath
  logic [31:0] res;

  always_comb begin
    res = 32'd0;
    case (ctl)
      4'b0000: res = bus.a & bus.b;
      4'b0001: res = bus.a | bus.b;
      4'b0010: res = bus.a + bus.b;
      4'b0110: res = bus.a - bus.b;
      4'b0111: res = {31'd0, ($signed(bus.a) < $signed(bus.b))};
      4'b1100: res = ~(bus.a | bus.b);
      4'b1101: res = bus.a ^ bus.b;
      default: res = 32'd0;
    endcase
  end

  assign bus.aluctl  = ctl;
  assign bus.alu_out = res;
  assign bus.zero    = (res == 32'd0);

  // Branch table storage
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      dst_q   [ENTRIES];
  logic             pred_q  [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_hit;
  logic             wr_match;

  assign rd_idx = bus.pc4[IDX_W+1:2];
  assign rd_tag = bus.pc4[31:IDX_W+2];
  assign wr_idx = bus.pc4d[IDX_W+1:2];
  assign wr_tag = bus.pc4d[31:IDX_W+2];

  // Word-aligned PCs: the byte-offset bits carry no information.
  logic unused_byte_bits;
  assign unused_byte_bits = &{1'b0, bus.pc4[1:0], bus.pc4d[1:0]};

  assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Misses present zeros rather than whatever stale entry sits at the index.
  assign bus.hit   = rd_hit;
  assign bus.bdest = rd_hit ? dst_q[rd_idx] : 32'd0;
  assign bus.pred  = rd_hit ? pred_q[rd_idx] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        dst_q[i]   <= 32'd0;
        pred_q[i]  <= 1'b0;
      end
    end else if (bus.wrt) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      dst_q[wr_idx]   <= bus.bdest_in;
      pred_q[wr_idx]  <= bus.pin;
    end else if (bus.wrp && wr_match) begin
      // Prediction-only update must not disturb an entry owned by another branch.
      pred_q[wr_idx] <= bus.pin;
    end
  end
endmodule

// File: tb/tb_alu_branch_table.sv
// tb/tb_alu_branch_table.sv - self-checking bench for alu_branch_table
module tb_alu_branch_table;
  localparam int ENTRIES = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_branch_table_if bus_if ();

  alu_branch_table #(.ENTRIES(ENTRIES), .IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference ALU: operation chosen by name, then plain arithmetic.
  function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 4'h2;
    if (op == 2'd1) return 4'h6;
    if (op == 2'd3) return 4'h0;
    case (f)
      6'h20: return 4'h2;
      6'h22: return 4'h6;
      6'h24: return 4'h0;
      6'h25: return 4'h1;
      6'h26: return 4'hD;
      6'h27: return 4'hC;
      6'h2A: return 4'h7;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (c)
      4'h0: return x & y;
      4'h1: return x | y;
      4'h2: return x + y;
      4'h6: return x - y;
      4'h7: return (sx < sy) ? 32'd1 : 32'd0;
      4'hC: return ~(x | y);
      4'hD: return x ^ y;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] res;
  } alu_vec_t;

  alu_vec_t vecs[15];

  // Table reference model
  logic        m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_dst   [ENTRIES];
  logic        m_pred  [ENTRIES];

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'd0;
      m_dst[i]   = 32'd0;
      m_pred[i]  = 1'b0;
    end
  endtask

  task automatic check_table(input string name, input logic h, input logic [31:0] d, input logic p);
    check({name, ".hit"},   {31'd0, bus_if.hit}, {31'd0, h});
    check({name, ".bdest"}, bus_if.bdest, d);
    check({name, ".pred"},  {31'd0, bus_if.pred}, {31'd0, p});
  endtask

  function automatic logic [31:0] mk_pc(input int unsigned tag, input int unsigned idx);
    return tag * (4 * ENTRIES) + idx * 4 + $urandom_range(0, 3);
  endfunction

  initial begin
    logic [5:0]  fl[8];
    int unsigned ix, dx;
    logic [31:0] tg, dt;
    logic        eh;
    logic [3:0]  ec;
    logic [31:0] er;

    checks = 0;
    errors = 0;
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25;
    fl[4] = 6'h26; fl[5] = 6'h27; fl[6] = 6'h2A; fl[7] = 6'h00;

    vecs[0]  = '{2'b10, 6'h20, 32'd3, 32'd4, 4'h2, 32'd7};
    vecs[1]  = '{2'b10, 6'h22, 32'd5, 32'd7, 4'h6, 32'hFFFFFFFE};
    vecs[2]  = '{2'b10, 6'h24, 32'hF0F0, 32'hFF00, 4'h0, 32'hF000};
    vecs[3]  = '{2'b10, 6'h25, 32'hF0F0, 32'hFF00, 4'h1, 32'hFFF0};
    vecs[4]  = '{2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 4'h7, 32'd1};
    vecs[5]  = '{2'b10, 6'h2A, 32'd1, 32'hFFFFFFFF, 4'h7, 32'd0};
    vecs[6]  = '{2'b10, 6'h27, 32'd0, 32'd0, 4'hC, 32'hFFFFFFFF};
    vecs[7]  = '{2'b10, 6'h26, 32'hF0F0, 32'hFF00, 4'hD, 32'h0FF0};
    vecs[8]  = '{2'b00, 6'h22, 32'hFFFFFFFF, 32'd1, 4'h2, 32'd0};
    vecs[9]  = '{2'b01, 6'h20, 32'd5, 32'd7, 4'h6, 32'hFFFFFFFE};
    vecs[10] = '{2'b11, 6'h25, 32'h1234, 32'h00FF, 4'h0, 32'h0034};
    vecs[11] = '{2'b10, 6'h3F, 32'hAAAA, 32'h0F0F, 4'h0, 32'h0A0A};
    vecs[12] = '{2'b10, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 4'h7, 32'd1};
    vecs[13] = '{2'b10, 6'h22, 32'h12345678, 32'h12345678, 4'h6, 32'd0};
    vecs[14] = '{2'b10, 6'h2A, 32'd9, 32'd9, 4'h7, 32'd0};

    bus_if.aluop = 2'b00; bus_if.funct = 6'h00; bus_if.a = 32'd0; bus_if.b = 32'd0;
    bus_if.pc4 = 32'd0; bus_if.pc4d = 32'd0; bus_if.wrt = 1'b0; bus_if.wrp = 1'b0;
    bus_if.bdest_in = 32'd0; bus_if.pin = 1'b0;
    rst_n = 1'b0;
    model_clear();

    // Reset state and write-ignored-while-in-reset
    #1;
    bus_if.pc4 = 32'h14;
    bus_if.pc4d = 32'h14; bus_if.wrt = 1'b1; bus_if.bdest_in = 32'h99; bus_if.pin = 1'b1;
    #1 check_table("reset", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    bus_if.wrt = 1'b0;
    #1 check_table("reset_wr_ignored", 1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;

    // ALU vector table
    foreach (vecs[i]) begin
      bus_if.aluop = vecs[i].op; bus_if.funct = vecs[i].f;
      bus_if.a = vecs[i].a; bus_if.b = vecs[i].b;
      #1;
      check($sformatf("vec%0d.aluctl", i), {28'd0, bus_if.aluctl}, {28'd0, vecs[i].ctl});
      check($sformatf("vec%0d.alu_out", i), bus_if.alu_out, vecs[i].res);
      check($sformatf("vec%0d.zero", i), {31'd0, bus_if.zero}, {31'd0, vecs[i].res == 32'd0});
    end

    // Randomized ALU against reference
    for (int n = 0; n < 200; n++) begin
      bus_if.aluop = 2'($urandom_range(0, 3));
      bus_if.funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 7)];
      bus_if.a = $urandom;
      bus_if.b = ($urandom_range(0, 7) == 0) ? bus_if.a : $urandom;
      #1;
      ec = ref_ctl(bus_if.aluop, bus_if.funct);
      er = ref_alu(ec, bus_if.a, bus_if.b);
      check("rnd.aluctl", {28'd0, bus_if.aluctl}, {28'd0, ec});
      check("rnd.alu_out", bus_if.alu_out, er);
      check("rnd.zero", {31'd0, bus_if.zero}, {31'd0, er == 32'd0});
    end

    // Write then read-back with same-cycle bypass absent
    @(negedge clk);
    bus_if.wrt = 1'b1; bus_if.pc4d = 32'h14; bus_if.bdest_in = 32'h40; bus_if.pin = 1'b1;
    bus_if.pc4 = 32'h14;
    #1 check_table("wr_same_cycle", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    bus_if.wrt = 1'b0;
    #1 check_table("wr_next_cycle", 1'b1, 32'h40, 1'b1);
    bus_if.pc4 = 32'h54;
    #1 check_table("alias_miss", 1'b0, 32'd0, 1'b0);

    // Prediction-only update, matching and non-matching tag
    bus_if.wrp = 1'b1; bus_if.pin = 1'b0; bus_if.pc4d = 32'h14; bus_if.pc4 = 32'h14;
    @(negedge clk);
    bus_if.wrp = 1'b0;
    #1 check_table("wrp_match", 1'b1, 32'h40, 1'b0);
    bus_if.wrp = 1'b1; bus_if.pin = 1'b1; bus_if.pc4d = 32'h54;
    @(negedge clk);
    bus_if.wrp = 1'b0;
    #1 check_table("wrp_nomatch", 1'b1, 32'h40, 1'b0);
    bus_if.pc4 = 32'h54;
    #1 check_table("wrp_nomatch_alias", 1'b0, 32'd0, 1'b0);

    // Async reset between edges, writes ignored while low
    bus_if.pc4 = 32'h14;
    #2 rst_n = 1'b0;
    #1 check_table("async_reset", 1'b0, 32'd0, 1'b0);
    bus_if.wrt = 1'b1; bus_if.pc4d = 32'h14; bus_if.bdest_in = 32'h77; bus_if.pin = 1'b1;
    @(negedge clk);
    bus_if.wrt = 1'b0;
    rst_n = 1'b1;
    #1 check_table("after_release", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1 check_table("after_release_edge", 1'b0, 32'd0, 1'b0);

    // Randomized table traffic against array model
    model_clear();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus_if.pc4  = ($urandom_range(0, 15) == 0) ? $urandom : mk_pc($urandom_range(0, 2), $urandom_range(0, ENTRIES - 1));
      bus_if.pc4d = mk_pc($urandom_range(0, 2), $urandom_range(0, ENTRIES - 1));
      bus_if.wrt  = ($urandom_range(0, 3) == 0);
      bus_if.wrp  = ($urandom_range(0, 2) == 0);
      bus_if.bdest_in = $urandom;
      bus_if.pin  = 1'($urandom_range(0, 1));
      #1;
      ix = (bus_if.pc4 / 4) % ENTRIES;
      tg = bus_if.pc4 / (4 * ENTRIES);
      eh = m_valid[ix] && (m_tag[ix] == tg);
      check_table("rnd_tbl", eh, eh ? m_dst[ix] : 32'd0, eh ? m_pred[ix] : 1'b0);
      @(posedge clk);
      dx = (bus_if.pc4d / 4) % ENTRIES;
      dt = bus_if.pc4d / (4 * ENTRIES);
      if (bus_if.wrt) begin
        m_valid[dx] = 1'b1;
        m_tag[dx]   = dt;
        m_dst[dx]   = bus_if.bdest_in;
        m_pred[dx]  = bus_if.pin;
      end else if (bus_if.wrp && m_valid[dx] && m_tag[dx] == dt) begin
        m_pred[dx] = bus_if.pin;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
